// File: rtl/riscv_pkg.sv
// Shared RV32 definitions used by the multiply/divide unit: the operation encoding, FSM states
// and the two's-complement helpers.
package riscv_pkg;

  localparam int XLEN = 32;

  // Encoded to match funct3 of the RV32M instructions
  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  function automatic logic [XLEN-1:0] neg_val(input logic [XLEN-1:0] x);
    return ~x + XLEN'(1);
  endfunction

  // Magnitude of a signed value; 0x80000000 maps to itself, which is 2^31 read as unsigned
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x);
    return x[XLEN-1] ? neg_val(x) : x;
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the control unit and the multiply/divide unit.
interface muldiv_unit_if;
  import riscv_pkg::*;

  logic            start;
  muldiv_op_t      op;
  logic [XLEN-1:0] opr_a;
  logic [XLEN-1:0] opr_b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, opr_a, opr_b, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, op, opr_a, opr_b, flush,
    output busy, done, result
  );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit: 32 shift-add or restoring shift-subtract steps
// on operand magnitudes, with sign fix-up on the last step and an early-out for divide corner cases.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_unit_if.slave io
);
  import riscv_pkg::*;

  muldiv_state_t     state_r;
  muldiv_state_t     state_nx_s;
  muldiv_op_t        op_r;
  logic [XLEN-1:0]   a_mag_r;
  logic [XLEN-1:0]   b_mag_r;
  logic [XLEN-1:0]   quot_r;
  logic [XLEN-1:0]   result_r;
  logic [2*XLEN-1:0] prod_r;
  logic [XLEN:0]     rem_r;
  logic [4:0]        cnt_r;
  logic              neg_xor_r;
  logic              neg_a_r;
  logic              busy_r;
  logic              done_r;

  logic              a_signed_s;
  logic              b_signed_s;
  logic              a_neg_s;
  logic              b_neg_s;
  logic [XLEN-1:0]   a_mag_s;
  logic [XLEN-1:0]   b_mag_s;
  logic              div_zero_s;
  logic              div_ovf_s;
  logic              special_s;
  logic [XLEN-1:0]   spec_res_s;
  logic              load_s;
  logic              step_s;
  logic              last_s;

  logic [XLEN:0]     sum_s;
  logic [2*XLEN-1:0] prod_nx_s;
  logic [XLEN:0]     shift_s;
  logic [XLEN:0]     diff_s;
  logic [XLEN:0]     rem_nx_s;
  logic [XLEN-1:0]   quot_nx_s;
  logic [2*XLEN-1:0] prod_fix_s;
  logic [XLEN-1:0]   quot_fix_s;
  logic [XLEN-1:0]   rem_fix_s;
  logic [XLEN-1:0]   final_res_s;

  assign io.busy   = busy_r;
  assign io.done   = done_r;
  assign io.result = result_r;

  // Operand signedness, magnitudes and divide corner-case detection on the incoming request
  always_comb begin
    a_signed_s = 1'b0;
    b_signed_s = 1'b0;
    case (io.op)
      MUL, MULH, DIV, REM: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b1;
      end
      MULHSU: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b0;
      end
      default: begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
      end
    endcase

    a_neg_s    = a_signed_s & io.opr_a[XLEN-1];
    b_neg_s    = b_signed_s & io.opr_b[XLEN-1];
    a_mag_s    = a_neg_s ? abs_val(io.opr_a) : io.opr_a;
    b_mag_s    = b_neg_s ? abs_val(io.opr_b) : io.opr_b;
    div_zero_s = (io.opr_b == {XLEN{1'b0}});
    div_ovf_s  = ((io.op == DIV) || (io.op == REM)) &&
                 (io.opr_a == {1'b1, {(XLEN-1){1'b0}}}) && (io.opr_b == {XLEN{1'b1}});
    special_s  = io.op[2] & (div_zero_s | div_ovf_s);

    case (io.op)
      DIV:     spec_res_s = div_zero_s ? {XLEN{1'b1}} : {1'b1, {(XLEN-1){1'b0}}};
      DIVU:    spec_res_s = {XLEN{1'b1}};
      REM:     spec_res_s = div_zero_s ? io.opr_a : {XLEN{1'b0}};
      REMU:    spec_res_s = io.opr_a;
      default: spec_res_s = {XLEN{1'b0}};
    endcase
  end

  // Next-state logic; flush overrides everything including a simultaneous start
  always_comb begin
    state_nx_s = state_r;
    load_s     = 1'b0;
    step_s     = 1'b0;
    last_s     = 1'b0;
    if (io.flush) begin
      state_nx_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (io.start) begin
            load_s     = 1'b1;
            state_nx_s = special_s ? DONE : CALC;
          end else begin
            state_nx_s = IDLE;
          end
        end
        CALC: begin
          step_s = 1'b1;
          if (cnt_r == 5'd31) begin
            last_s     = 1'b1;
            state_nx_s = DONE;
          end else begin
            state_nx_s = CALC;
          end
        end
        DONE:    state_nx_s = IDLE;
        default: state_nx_s = IDLE;
      endcase
    end
  end

  // State register and the status outputs decoded from the upcoming state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s == CALC);
      done_r  <= (state_nx_s == DONE);
    end
  end

  // One radix-2 step for both datapaths; the quotient register doubles as the dividend shifter
  always_comb begin
    sum_s     = {1'b0, prod_r[2*XLEN-1:XLEN]} + {1'b0, (prod_r[0] ? b_mag_r : {XLEN{1'b0}})};
    prod_nx_s = {sum_s, prod_r[XLEN-1:1]};

    shift_s = {rem_r[XLEN-1:0], quot_r[XLEN-1]};
    diff_s  = shift_s - {1'b0, b_mag_r};
    if (!diff_s[XLEN]) begin
      rem_nx_s  = diff_s;
      quot_nx_s = {quot_r[XLEN-2:0], 1'b1};
    end else begin
      rem_nx_s  = shift_s;
      quot_nx_s = {quot_r[XLEN-2:0], 1'b0};
    end
  end

  // Sign correction and result selection applied to the final iteration's values
  always_comb begin
    prod_fix_s = neg_xor_r ? (~prod_nx_s + 64'd1) : prod_nx_s;
    quot_fix_s = neg_xor_r ? neg_val(quot_nx_s) : quot_nx_s;
    rem_fix_s  = neg_a_r ? neg_val(rem_nx_s[XLEN-1:0]) : rem_nx_s[XLEN-1:0];
    case (op_r)
      MUL:                 final_res_s = prod_fix_s[XLEN-1:0];
      MULH, MULHSU, MULHU: final_res_s = prod_fix_s[2*XLEN-1:XLEN];
      DIV, DIVU:           final_res_s = quot_fix_s;
      REM, REMU:           final_res_s = rem_fix_s;
      default:             final_res_s = {XLEN{1'b0}};
    endcase
  end

  // Datapath registers: latch on accept, iterate in CALC, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r      <= MUL;
      a_mag_r   <= {XLEN{1'b0}};
      b_mag_r   <= {XLEN{1'b0}};
      quot_r    <= {XLEN{1'b0}};
      prod_r    <= {(2*XLEN){1'b0}};
      rem_r     <= {(XLEN+1){1'b0}};
      cnt_r     <= 5'd0;
      neg_xor_r <= 1'b0;
      neg_a_r   <= 1'b0;
      result_r  <= {XLEN{1'b0}};
    end else if (load_s) begin
      op_r      <= io.op;
      a_mag_r   <= a_mag_s;
      b_mag_r   <= b_mag_s;
      quot_r    <= a_mag_s;
      prod_r    <= {{XLEN{1'b0}}, a_mag_s};
      rem_r     <= {(XLEN+1){1'b0}};
      cnt_r     <= 5'd0;
      neg_xor_r <= a_neg_s ^ b_neg_s;
      neg_a_r   <= a_neg_s;
      if (special_s) begin
        result_r <= spec_res_s;
      end else begin
        result_r <= result_r;
      end
    end else if (step_s) begin
      prod_r <= prod_nx_s;
      rem_r  <= rem_nx_s;
      quot_r <= quot_nx_s;
      cnt_r  <= cnt_r + 5'd1;
      if (last_s) begin
        result_r <= final_res_s;
      end else begin
        result_r <= result_r;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, random ops against an arithmetic
// reference model, and hand-written abort/reset sequences.
module tb_muldiv_unit;
  import riscv_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  muldiv_unit_if io();

  muldiv_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    muldiv_op_t  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input muldiv_op_t op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = 64'd0;
    case (op)
      MUL:    begin p = sa * sb; return p[31:0]; end
      MULH:   begin p = sa * sb; return p[63:32]; end
      MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
      MULHU:  begin p = ua * ub; return p[63:32]; end
      DIV:    begin if (b == 32'd0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
      REM:    begin if (b == 32'd0) return a; p = sa % sb; return p[31:0]; end
      DIVU:   begin if (b == 32'd0) return 32'hFFFFFFFF; p = ua / ub; return p[31:0]; end
      REMU:   begin if (b == 32'd0) return a; p = ua % ub; return p[31:0]; end
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
    bit sdiv;
    sdiv = (op == DIV) || (op == REM);
    if ((op == DIV || op == DIVU || op == REM || op == REMU) &&
        (b == 32'd0 || (sdiv && a == 32'h80000000 && b == 32'hFFFFFFFF)))
      return 0;
    return 32;
  endfunction

  // Presents one request for exactly one clock edge; returns just after that edge
  task automatic start_op(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    io.start = 1'b1;
    io.op    = op;
    io.opr_a = a;
    io.opr_b = b;
    @(posedge clk);
    #1;
    io.start = 1'b0;
    io.opr_a = 32'hDEADBEEF;
    io.opr_b = 32'h12345678;
  endtask

  // Counts edges after the start edge until done is seen; checks busy before done and a one-cycle pulse
  task automatic wait_done(output int lat, output logic [31:0] res, output bit shape_ok);
    lat      = 0;
    shape_ok = 1'b1;
    forever begin
      @(negedge clk);
      if (io.done) break;
      if (!io.busy) shape_ok = 1'b0;
      if (lat >= 40) break;
      @(posedge clk);
      lat++;
    end
    res = io.result;
    if (io.busy) shape_ok = 1'b0;
    @(negedge clk);
    if (io.done || io.busy) shape_ok = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] res;
    bit          shape_ok;
    muldiv_op_t  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int          sel;
    bit          saw_done;

    n_checks = 0;
    n_fail   = 0;

    vecs[0]  = '{MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 32};
    vecs[1]  = '{MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 32};
    vecs[2]  = '{MULH,   32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, 32};
    vecs[3]  = '{MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 32};
    vecs[4]  = '{DIV,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 32};
    vecs[5]  = '{REM,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 32};
    vecs[6]  = '{DIVU,   32'd100,        32'd7,        32'd14,       32};
    vecs[7]  = '{REMU,   32'd100,        32'd7,        32'd2,        32};
    vecs[8]  = '{DIV,    32'd5,          32'd0,        32'hFFFFFFFF, 0};
    vecs[9]  = '{REM,    32'd5,          32'd0,        32'd5,        0};
    vecs[10] = '{DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, 0};
    vecs[11] = '{REM,    32'h80000000,   32'hFFFFFFFF, 32'd0,        0};
    vecs[12] = '{DIVU,   32'd5,          32'd0,        32'hFFFFFFFF, 0};
    vecs[13] = '{REMU,   32'd9,          32'd0,        32'd9,        0};
    vecs[14] = '{MUL,    32'h80000000,   32'h80000000, 32'd0,        32};
    vecs[15] = '{MULH,   32'h80000000,   32'h80000000, 32'h40000000, 32};

    rst_n    = 1'b0;
    io.start = 1'b0;
    io.op    = MUL;
    io.opr_a = 32'd0;
    io.opr_b = 32'd0;
    io.flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_busy",   {31'd0, io.busy}, 32'd0);
    check("reset_done",   {31'd0, io.done}, 32'd0);
    check("reset_result", io.result,        32'd0);

    // flush beats a simultaneous start
    @(negedge clk);
    io.start = 1'b1;
    io.flush = 1'b1;
    io.op    = MUL;
    io.opr_a = 32'd3;
    io.opr_b = 32'd3;
    @(posedge clk);
    #1;
    io.start = 1'b0;
    io.flush = 1'b0;
    @(negedge clk);
    check("flush_start_busy", {31'd0, io.busy}, 32'd0);
    check("flush_start_done", {31'd0, io.done}, 32'd0);

    for (int i = 0; i < 16; i++) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(lat, res, shape_ok);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_shape", i), {31'd0, shape_ok}, 32'd1);
    end

    for (int i = 0; i < 60; i++) begin
      rop = muldiv_op_t'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) rb = 32'hFFFFFFFF;
      else if (sel == 2) rb = $urandom_range(1, 15);
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      start_op(rop, ra, rb);
      wait_done(lat, res, shape_ok);
      check($sformatf("rand%0d_%s_%08h_%08h", i, rop.name(), ra, rb), res, ref_model(rop, ra, rb));
      check($sformatf("rand%0d_latency", i), lat, ref_lat(rop, ra, rb));
    end

    // start while busy is ignored: done still comes 32 edges after the first start
    start_op(DIVU, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    start_op(MUL, 32'd3, 32'd3);
    wait_done(lat, res, shape_ok);
    check("busy_start_result",  res, 32'd14);
    check("busy_start_latency", lat, 32'd27);

    // flush at cycle 10 of a second operation
    start_op(DIVU, 32'd50, 32'd5);
    repeat (9) @(posedge clk);
    @(negedge clk);
    io.flush = 1'b1;
    @(posedge clk);
    #1;
    io.flush = 1'b0;
    @(negedge clk);
    check("flush_busy", {31'd0, io.busy}, 32'd0);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (io.done) saw_done = 1'b1;
    end
    check("flush_no_done", {31'd0, saw_done}, 32'd0);
    check("flush_result",  io.result,         32'd14);

    // asynchronous reset mid-CALC, between edges
    start_op(MUL, 32'd6, 32'd7);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy",   {31'd0, io.busy}, 32'd0);
    check("async_rst_done",   {31'd0, io.done}, 32'd0);
    check("async_rst_result", io.result,        32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (io.done || io.busy) saw_done = 1'b1;
    end
    check("post_rst_idle", {31'd0, saw_done}, 32'd0);
    start_op(MUL, 32'd6, 32'd7);
    wait_done(lat, res, shape_ok);
    check("post_rst_result",  res, 32'd42);
    check("post_rst_latency", lat, 32'd32);
    check("post_rst_shape",   {31'd0, shape_ok}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
